// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EX, waits for the data-SRAM
// response of issued loads/stores, aligns and extends load data, and drops
// responses that belong to requests flushed by a WB exception.
module mem_stage #(
    parameter int CANCEL_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic        es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_result,
    input  logic        es_res_from_mem,
    input  logic        es_mem_issued,
    input  logic [4:0]  es_ld_inst,
    input  logic        es_csr_re,
    input  logic [85:0] es_ex_zip,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    input  logic        wb_ex,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic        ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_final_result,
    output logic        ms_res_from_mem,
    output logic        ms_csr_re,
    output logic [85:0] ms_ex_zip,
    output logic        ms_ex
);

    // Bit positions inside the {ld_b, ld_bu, ld_h, ld_hu, ld_w} load-type vector.
    localparam int LD_B  = 4;
    localparam int LD_BU = 3;
    localparam int LD_H  = 2;
    localparam int LD_HU = 1;
    localparam int LD_W  = 0;

    logic                ms_valid_q, ms_valid_d;
    logic [31:0]         pc_q, pc_d;
    logic                rf_we_q, rf_we_d;
    logic [4:0]          rf_waddr_q, rf_waddr_d;
    logic [31:0]         result_q, result_d;
    logic                res_from_mem_q, res_from_mem_d;
    logic                mem_issued_q, mem_issued_d;
    logic [4:0]          ld_inst_q, ld_inst_d;
    logic                csr_re_q, csr_re_d;
    logic [85:0]         ex_zip_q, ex_zip_d;
    logic                buf_v_q, buf_v_d;
    logic [31:0]         buf_q, buf_d;
    logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

    logic        cnt_zero;
    logic        resp_ok;
    logic        ms_ready_go;
    logic        capture;
    logic        cnt_inc;
    logic        cnt_dec;
    logic [31:0] rdata_src;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] final_result;

    // Handshake: a response only counts for this instruction once all orphans are drained.
    always_comb begin
        cnt_zero       = (cancel_cnt_q == '0);
        resp_ok        = data_sram_data_ok & cnt_zero;
        ms_ready_go    = ~mem_issued_q | buf_v_q | resp_ok;
        ms_allowin     = ~ms_valid_q | (ms_ready_go & wb_allowin);
        ms_to_ws_valid = ms_valid_q & ms_ready_go & ~wb_ex;
        capture        = resp_ok & ms_valid_q & mem_issued_q & ~buf_v_q & ~wb_allowin;
        cnt_inc        = wb_ex & ms_valid_q & mem_issued_q & ~buf_v_q & ~data_sram_data_ok;
        cnt_dec        = data_sram_data_ok & ~cnt_zero;
    end

    // Next-state for the pipeline registers, response buffer and orphan counter.
    always_comb begin
        ms_valid_d     = ms_valid_q;
        pc_d           = pc_q;
        rf_we_d        = rf_we_q;
        rf_waddr_d     = rf_waddr_q;
        result_d       = result_q;
        res_from_mem_d = res_from_mem_q;
        mem_issued_d   = mem_issued_q;
        ld_inst_d      = ld_inst_q;
        csr_re_d       = csr_re_q;
        ex_zip_d       = ex_zip_q;
        buf_v_d        = buf_v_q;
        buf_d          = buf_q;
        cancel_cnt_d   = cancel_cnt_q;

        if (wb_ex) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        // capture needs ~ms_allowin, so it can never coincide with a transfer in
        if (es_to_ms_valid && ms_allowin) begin
            pc_d           = es_pc;
            rf_we_d        = es_rf_we;
            rf_waddr_d     = es_rf_waddr;
            result_d       = es_result;
            res_from_mem_d = es_res_from_mem;
            mem_issued_d   = es_mem_issued;
            ld_inst_d      = es_ld_inst;
            csr_re_d       = es_csr_re;
            ex_zip_d       = es_ex_zip;
            buf_v_d        = 1'b0;
        end else if (capture) begin
            buf_v_d = 1'b1;
            buf_d   = data_sram_rdata;
        end

        if (cnt_inc && !cnt_dec && (cancel_cnt_q != '1)) begin
            cancel_cnt_d = cancel_cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cancel_cnt_d = cancel_cnt_q - 1'b1;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            pc_q           <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            result_q       <= '0;
            res_from_mem_q <= 1'b0;
            mem_issued_q   <= 1'b0;
            ld_inst_q      <= '0;
            csr_re_q       <= 1'b0;
            ex_zip_q       <= '0;
            buf_v_q        <= 1'b0;
            buf_q          <= '0;
            cancel_cnt_q   <= '0;
        end else begin
            ms_valid_q     <= ms_valid_d;
            pc_q           <= pc_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            result_q       <= result_d;
            res_from_mem_q <= res_from_mem_d;
            mem_issued_q   <= mem_issued_d;
            ld_inst_q      <= ld_inst_d;
            csr_re_q       <= csr_re_d;
            ex_zip_q       <= ex_zip_d;
            buf_v_q        <= buf_v_d;
            buf_q          <= buf_d;
            cancel_cnt_q   <= cancel_cnt_d;
        end
    end

    // Load alignment and sign/zero extension; non-loads pass the EX result through.
    always_comb begin
        rdata_src = buf_v_q ? buf_q : data_sram_rdata;
        case (result_q[1:0])
            2'd0:    byte_sel = rdata_src[7:0];
            2'd1:    byte_sel = rdata_src[15:8];
            2'd2:    byte_sel = rdata_src[23:16];
            default: byte_sel = rdata_src[31:24];
        endcase
        half_sel     = result_q[1] ? rdata_src[31:16] : rdata_src[15:0];
        final_result = result_q;
        if (res_from_mem_q) begin
            if (ld_inst_q[LD_B]) begin
                final_result = {{24{byte_sel[7]}}, byte_sel};
            end else if (ld_inst_q[LD_BU]) begin
                final_result = {24'h0, byte_sel};
            end else if (ld_inst_q[LD_H]) begin
                final_result = {{16{half_sel[15]}}, half_sel};
            end else if (ld_inst_q[LD_HU]) begin
                final_result = {16'h0, half_sel};
            end else if (ld_inst_q[LD_W]) begin
                final_result = rdata_src;
            end
        end
    end

    assign ms_pc           = pc_q;
    assign ms_rf_we        = ms_valid_q & rf_we_q;
    assign ms_rf_waddr     = rf_waddr_q;
    assign ms_final_result = final_result;
    assign ms_res_from_mem = ms_valid_q & res_from_mem_q & ~ms_ready_go;
    assign ms_csr_re       = csr_re_q;
    assign ms_ex_zip       = ex_zip_q;
    assign ms_ex           = ms_valid_q & (|ex_zip_q[6:0]);

endmodule
